serial_adder_seq: RTL
=====================

Name: serial_adder_seq

Overview:
Bit-serial adder stage that drives the team's 1-bit full-adder cell one bit per clock.
- Accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake.
- Shifts the operands LSB-first through a full-adder slice with a registered carry.
- Reassembles the sum, then presents it on a valid/ready output handshake.
- Sits between the operand source (ui_in-side logic) and the result consumer (uo_out-side logic), trading area for WIDTH cycles of latency.

Parameters:
WIDTH, 8, operand and sum width in bits (WIDTH >= 2)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous reset, active-low
ena  input  1  global enable; when 0 all registers hold and in_ready is 0
in_valid  input  1  operand bundle valid
in_ready  output  1  stage can accept operands
a_in  input  WIDTH  operand A
b_in  input  WIDTH  operand B
cin  input  1  carry-in
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum_out  output  WIDTH  A + B + cin, low WIDTH bits
cout  output  1  carry out of bit WIDTH-1
ser_bit  output  1  sum bit produced this cycle (debug/serial tap)
ser_valid  output  1  ser_bit is meaningful this cycle

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - Asserting rst_n low immediately forces state=IDLE.
  - Operand shift registers, result register, carry register and bit counter go to 0.
  - Outputs during and after reset: in_ready=0 while rst_n=0, then in_ready=ena; out_valid=0, sum_out=0, cout=0, ser_bit=0, ser_valid=0.
- Reset mid-operation: the in-flight operation is discarded, with no partial result or out_valid pulse. There is no recovery and no replay.
- ena=0: every register holds and in_ready=0. out_valid, sum_out, cout and ser_bit keep their registered values. ser_valid=0. Latency stretches by the number of ena=0 cycles.
- FSM states: IDLE, ADD, HOLD.
  - IDLE: in_ready=ena.
    - Acceptance on a rising edge with in_valid & in_ready & ena.
    - On acceptance: load opA<=a_in, opB<=b_in, carry<=cin, cnt<=0, go ADD.
  - ADD: each enabled cycle, combinationally:
    - s = opA[0]^opB[0]^carry
    - c = majority(opA[0], opB[0], carry)
    - ser_bit=s, ser_valid=1
    - On the edge: opA, opB shift right; result shifts right with s entering at MSB; carry<=c; cnt<=cnt+1.
    - When cnt==WIDTH-1 on the edge: cout<=c, out_valid<=1, go HOLD.
    - cnt width is clog2(WIDTH) bits; no wrap occurs.
  - HOLD: sum_out=result and cout are stable while out_valid=1. On an edge with out_ready & ena: out_valid<=0, go IDLE.
- Latency: the operand accept edge is edge 0, and out_valid rises after edge WIDTH (8 for default).
- Throughput: one operation per WIDTH+2 cycles minimum, since there is no same-cycle accept on the release edge. in_ready rises the cycle after out handshake completes.
- in_valid, a_in, b_in and cin are ignored outside IDLE. Input values need only be stable on the accept edge.
- out_ready asserted before out_valid has no effect. out_ready held high gives a one-cycle out_valid pulse.
- sum_out/cout retain the last result after handshake until the next result overwrites them. Only reset clears them.
- Arithmetic: {cout, sum_out} = a_in + b_in + cin exactly (WIDTH+1 bits); overflow appears only in cout.

Test Plan:
1. Reset then a_in=8'hFF, b_in=8'h01, cin=0, out_ready=1 -> out_valid high exactly 8 edges after accept, sum_out=8'h00, cout=1, out_valid one-cycle pulse.
2. a_in=8'hA5, b_in=8'h5A, cin=1 -> sum_out=8'h00, cout=1. Then a_in=8'h03, b_in=8'h01, cin=0 -> ser_bit sequence LSB-first 0,0,1,0,0,0,0,0 with ser_valid high 8 cycles, sum_out=8'h04, cout=0.
3. Backpressure: out_ready=0 for 5 cycles after out_valid, in_valid toggling with new operands -> sum_out/cout/out_valid stable, in_ready=0 throughout; out_ready=1 -> out_valid falls next edge, in_ready=1 the following cycle.
4. ena dropped for 4 cycles at bit 3 of 8'h7F+8'h01 -> ser_valid=0 and state frozen during the gap, out_valid at accept+12 edges, sum_out=8'h80, cout=0.
5. rst_n pulsed low asynchronously (mid-cycle) at bit 5 -> out_valid, ser_valid and in_ready drop immediately, no out_valid later. Next operation 8'h10+8'h20 completes normally with 8'h30, cout=0.
6. 1000 random operand/cin sets with random out_ready and ena gaps -> every result matches reference {cout,sum} = a+b+cin; no lost or duplicated results.

Source files
------------

// File: rtl/serial_adder_seq.sv
// Bit-serial adder: accepts two WIDTH-bit operands plus carry-in, adds them LSB-first
// through a single full-adder slice with a registered carry, then offers the sum.
module serial_adder_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout,
  output logic             ser_bit,
  output logic             ser_valid
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, ADD, HOLD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             out_valid_q, out_valid_d;
  logic             s_bit, c_bit;

  // Full-adder slice on the current LSBs.
  assign s_bit = opa_q[0] ^ opb_q[0] ^ carry_q;
  assign c_bit = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);

  always_comb begin
    state_d     = state_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    res_d       = res_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    out_valid_d = out_valid_q;
    if (ena) begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            opa_d   = a_in;
            opb_d   = b_in;
            carry_d = cin;
            cnt_d   = '0;
            state_d = ADD;
          end
        end
        ADD: begin
          opa_d   = opa_q >> 1;
          opb_d   = opb_q >> 1;
          res_d   = {s_bit, res_q[WIDTH-1:1]};
          carry_d = c_bit;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            // Separate output register keeps the previous sum visible during the next add.
            sum_d       = res_d;
            cout_d      = c_bit;
            out_valid_d = 1'b1;
            cnt_d       = '0;
            state_d     = HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      opa_q       <= '0;
      opb_q       <= '0;
      res_q       <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      res_q       <= res_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = rst_n & ena & (state_q == IDLE);
  assign ser_valid = ena & (state_q == ADD);
  assign ser_bit   = (state_q == ADD) & s_bit;
  assign out_valid = out_valid_q;
  assign sum_out   = sum_q;
  assign cout      = cout_q;

endmodule
